uart_frame_rx: RTL and testbench

- Serial frame receiver for the board-state link.
- Deserializes 8N1 UART bytes on a single line, LSB first.
- Assembles FRAME_BYTES bytes into one frame and presents the low PAYLOAD_W bits in parallel with a one-cycle ready strobe.
- Sits at the link input, fed by the matching frame transmitter and feeding game logic.

---
 rtl/uart_link_pkg.sv | 22 ++
 rtl/uart_byte_rx.sv | 133 +++++++++++++
 rtl/uart_frame_rx.sv | 95 +++++++++
 tb/tb_uart_frame_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared definitions for the board-state serial link: default timing/frame sizes,
// the byte receiver state encoding and a byte-count width helper.
package uart_link_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int FRAME_BYTES_DEF  = 26;
  localparam int PAYLOAD_W_DEF    = 162;
  localparam int BYTE_CNT_W_DEF   = $clog2(FRAME_BYTES_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } byte_state_t;

  function automatic int byteCntWidth(input int frameBytes);
    return $clog2(frameBytes + 1);
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-flop input synchronizer, mid-bit sampling and the byte FSM.
// Define UART_FRAME_RX_PARITY_EN to expect an even-parity bit between D7 and stop.
module uart_byte_rx
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
`ifdef UART_FRAME_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       idle
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1, r_sync2, r_rxPrev;
  logic          w_rx, w_fall, w_tick;
  logic          w_stopOk, w_stopBad, w_parityBad;
  byte_state_t   r_state, w_nextState;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_byteValid, r_frameErr;
`ifdef UART_FRAME_RX_PARITY_EN
  logic          r_parityErr;
`endif

  assign w_rx   = r_sync2;
  assign w_fall = r_rxPrev & ~w_rx;

  // Synchronizer and edge-detect flops reset to the idle-high line level.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= rx;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_tick      = 1'b0;
    w_stopOk    = 1'b0;
    w_stopBad   = 1'b0;
    w_parityBad = 1'b0;
    case (r_state)
      IDLE: if (w_fall) w_nextState = START;
      START: begin
        w_tick = (r_cnt == HALF_LAST);
        if (w_tick) w_nextState = w_rx ? IDLE : DATA;
      end
      DATA: begin
        w_tick = (r_cnt == BIT_LAST);
        if (w_tick && r_bitIdx == 3'd7) begin
`ifdef UART_FRAME_RX_PARITY_EN
          w_nextState = PARITY;
`else
          w_nextState = STOP;
`endif
        end
      end
      PARITY: begin
        w_tick = (r_cnt == BIT_LAST);
        if (w_tick) begin
          w_parityBad = (w_rx != ^r_shift);
          w_nextState = w_parityBad ? IDLE : STOP;
        end
      end
      STOP: begin
        w_tick = (r_cnt == BIT_LAST);
        if (w_tick) begin
          w_stopOk    = w_rx;
          w_stopBad   = ~w_rx;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The bit counter restarts on every sample so each later sample lands mid-bit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt       <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;
`ifdef UART_FRAME_RX_PARITY_EN
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_cnt <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      if (r_state == START) begin
        r_bitIdx <= '0;
      end else if (r_state == DATA && w_tick) begin
        r_bitIdx <= r_bitIdx + 1'b1;
        r_shift  <= {w_rx, r_shift[7:1]};
      end
      r_byteValid <= w_stopOk;
      r_frameErr  <= w_stopBad | w_parityBad;
`ifdef UART_FRAME_RX_PARITY_EN
      r_parityErr <= w_parityBad;
`endif
    end
  end

  assign byte_data  = r_shift;
  assign byte_valid = r_byteValid;
  assign frame_err  = r_frameErr;
  assign idle       = (r_state == IDLE);
`ifdef UART_FRAME_RX_PARITY_EN
  assign parity_err = r_parityErr;
`endif

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: collects FRAME_BYTES UART bytes and presents the low PAYLOAD_W bits.
// Define UART_FRAME_RX_PARITY_EN for even-parity bytes and the parity_err pulse output.
module uart_frame_rx
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FRAME_BYTES  = FRAME_BYTES_DEF,
  parameter int PAYLOAD_W    = PAYLOAD_W_DEF,
  parameter int IDLE_TIMEOUT = 20 * CLKS_PER_BIT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 ready
`ifdef UART_FRAME_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int BCW = byteCntWidth(FRAME_BYTES);
  localparam int TW  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BCW-1:0] LAST_BYTE    = BCW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(IDLE_TIMEOUT - 1);

  logic [7:0]           w_byte;
  logic                 w_byteValid, w_frameErr, w_idle, w_timeout;
  logic [BCW-1:0]       r_byteCnt;
  logic [TW-1:0]        r_idleCnt;
  logic [PAYLOAD_W-1:0] r_frame, r_dataOut;
  logic                 r_frameDone, r_ready;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rx        (rx),
    .byte_data (w_byte),
    .byte_valid(w_byteValid),
    .frame_err (w_frameErr),
`ifdef UART_FRAME_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .idle      (w_idle)
  );

  assign w_timeout = (r_byteCnt != '0) && w_idle && (r_idleCnt == TIMEOUT_LAST);

  // A bad byte or a long idle gap inside a frame drops the partial frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_byteCnt   <= '0;
      r_idleCnt   <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_byteValid && (r_byteCnt == LAST_BYTE);
      if (w_frameErr)
        r_byteCnt <= '0;
      else if (w_byteValid)
        r_byteCnt <= (r_byteCnt == LAST_BYTE) ? '0 : r_byteCnt + 1'b1;
      else if (w_timeout)
        r_byteCnt <= '0;
      if (r_byteCnt == '0 || !w_idle || w_timeout)
        r_idleCnt <= '0;
      else
        r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  // Only payload bits are stored; bytes wholly above PAYLOAD_W just advance the count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_frame <= '0;
    end else if (w_byteValid) begin
      for (int b = 0; b < PAYLOAD_W; b++)
        if (r_byteCnt == BCW'(b / 8)) r_frame[b] <= w_byte[b % 8];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_dataOut <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= r_frameDone;
      if (r_frameDone) r_dataOut <= r_frame;
    end
  end

  assign data_out = r_dataOut;
  assign ready    = r_ready;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx with a byte-queue frame model.
// Builds with or without UART_FRAME_RX_PARITY_EN.
module tb_uart_frame_rx;

  localparam int CPB = 16;
  localparam int FB  = 26;
  localparam int PW  = 162;
  localparam int TO  = 20 * CPB;
`ifdef UART_FRAME_RX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int LAT_NOM = (FB * BITS - 1) * CPB + 13;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rx;
  logic [PW-1:0] data_out;
  logic          ready;
`ifdef UART_FRAME_RX_PARITY_EN
  logic          parity_err;
  int            parityErrCount = 0;
`endif

  int checks = 0;
  int errors = 0;
  int readyCount = 0;
  int cycleCnt = 0;
  int lastReadyCycle = 0;

  logic [7:0]    modelQ[$];
  int            modelReady = 0;
  logic [PW-1:0] modelData = '0;
  logic [7:0]    frameBuf[FB];

  always #5 clk_in = ~clk_in;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BYTES (FB),
    .PAYLOAD_W   (PW),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rx      (rx),
    .data_out(data_out),
    .ready   (ready)
`ifdef UART_FRAME_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always @(posedge clk_in) cycleCnt++;

  always @(negedge clk_in) begin
    if (ready === 1'b1) begin
      readyCount++;
      lastReadyCycle = cycleCnt;
    end
`ifdef UART_FRAME_RX_PARITY_EN
    if (parity_err === 1'b1) parityErrCount++;
`endif
  end

  task automatic checkOutput(input string tag, input logic [PW-1:0] observed, input logic [PW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: accepted bytes queue up; a full queue becomes the next payload.
  function automatic void modelAccept(input logic [7:0] b);
    logic [8*FB-1:0] full;
    modelQ.push_back(b);
    if (modelQ.size() == FB) begin
      full = '0;
      for (int k = 0; k < FB; k++) full[8*k +: 8] = modelQ[k];
      modelData = full[PW-1:0];
      modelReady++;
      modelQ.delete();
    end
  endfunction

  task automatic sendBit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk_in);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic goodStop, input logic goodParity);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
`ifdef UART_FRAME_RX_PARITY_EN
    sendBit(goodParity ? ^b : ~^b);
`endif
    sendBit(goodStop);
    if (goodStop && goodParity) begin
      modelAccept(b);
    end else begin
      modelQ.delete();
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk_in);
    end
  endtask

  task automatic idleFor(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk_in);
    if (cycles >= TO) modelQ.delete();
  endtask

  task automatic applyStimulus(input int nBytes);
    for (int k = 0; k < nBytes; k++) sendByte(frameBuf[k], 1'b1, 1'b1);
  endtask

  task automatic resetDut();
    rx = 1'b1;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    modelQ.delete();
    modelData = '0;
  endtask

  initial begin
    int t0;
    int lat;
    int errAt;
    rst_in = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk_in);
    rst_in = 1'b0;

    // reset after a stretch of idle line
    repeat (1000) @(negedge clk_in);
    resetDut();
    checkOutput("reset data_out", data_out, '0);
    checkOutput("reset ready", PW'(ready), PW'(0));
    idleFor(2000);
    checkOutput("idle no ready", PW'(readyCount), PW'(0));

    // nominal 0xAA frame
    for (int k = 0; k < FB; k++) frameBuf[k] = 8'hAA;
    t0 = cycleCnt;
    applyStimulus(FB);
    idleFor(2 * CPB);
    lat = lastReadyCycle - t0;
    $display("[TB] 0xAA frame ready latency %0d cycles", lat);
    checkOutput("aa ready count", PW'(readyCount), PW'(modelReady));
    checkOutput("aa data model", data_out, modelData);
    checkOutput("aa data literal", data_out, {2'b10, {20{8'hAA}}});
    checkOutput("aa latency", PW'(lat >= LAT_NOM - 8 && lat <= LAT_NOM + 8), PW'(1));
    idleFor(200);
    checkOutput("aa data held", data_out, {2'b10, {20{8'hAA}}});
    checkOutput("aa no extra ready", PW'(readyCount), PW'(1));

    // byte order 0x00..0x19
    for (int k = 0; k < FB; k++) frameBuf[k] = 8'(k);
    applyStimulus(FB);
    idleFor(2 * CPB);
    checkOutput("order ready count", PW'(readyCount), PW'(modelReady));
    checkOutput("order byte0", PW'(data_out[7:0]), PW'(8'h00));
    checkOutput("order byte1", PW'(data_out[15:8]), PW'(8'h01));
    checkOutput("order byte19", PW'(data_out[159:152]), PW'(8'h13));
    checkOutput("order top bits", PW'(data_out[161:160]), PW'(2'b00));

    // short glitch is a false start, then a clean frame
    rx = 1'b0;
    repeat (5) @(negedge clk_in);
    idleFor(4 * CPB);
    for (int k = 0; k < FB; k++) frameBuf[k] = 8'($urandom_range(0, 255));
    applyStimulus(FB);
    idleFor(2 * CPB);
    checkOutput("glitch ready count", PW'(readyCount), PW'(modelReady));
    checkOutput("glitch data", data_out, modelData);

    // framing error on byte 5 aborts the frame
    for (int k = 0; k < FB; k++) frameBuf[k] = 8'($urandom_range(0, 255));
    applyStimulus(5);
    sendByte(frameBuf[5], 1'b0, 1'b1);
    checkOutput("ferr no ready", PW'(readyCount), PW'(modelReady));
    applyStimulus(FB);
    idleFor(2 * CPB);
    checkOutput("ferr ready count", PW'(readyCount), PW'(modelReady));
    checkOutput("ferr data", data_out, modelData);

`ifdef UART_FRAME_RX_PARITY_EN
    // bad parity on byte 3 aborts the frame and pulses parity_err
    applyStimulus(3);
    sendByte(8'h5A, 1'b1, 1'b0);
    for (int k = 0; k < FB; k++) frameBuf[k] = 8'($urandom_range(0, 255));
    applyStimulus(FB);
    idleFor(2 * CPB);
    checkOutput("parity err pulses", PW'(parityErrCount), PW'(1));
    checkOutput("parity ready count", PW'(readyCount), PW'(modelReady));
    checkOutput("parity data", data_out, modelData);
`endif

    // idle timeout drops a 10-byte partial frame
    for (int k = 0; k < FB; k++) frameBuf[k] = 8'($urandom_range(0, 255));
    applyStimulus(10);
    idleFor(30 * CPB);
    for (int k = 0; k < FB; k++) frameBuf[k] = 8'h55;
    applyStimulus(FB);
    idleFor(2 * CPB);
    checkOutput("timeout ready count", PW'(readyCount), PW'(modelReady));
    checkOutput("timeout data model", data_out, modelData);
    checkOutput("timeout data literal", data_out, {2'b01, {20{8'h55}}});

    // reset in the middle of byte 12
    for (int k = 0; k < FB; k++) frameBuf[k] = 8'($urandom_range(0, 255));
    applyStimulus(12);
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(frameBuf[12][i]);
    resetDut();
    checkOutput("midreset data", data_out, modelData);
    idleFor(3 * CPB);
    applyStimulus(FB);
    idleFor(2 * CPB);
    checkOutput("midreset ready count", PW'(readyCount), PW'(modelReady));
    checkOutput("midreset data after", data_out, modelData);

    // random frames, back-to-back or short gaps, occasional framing errors
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < FB; k++) frameBuf[k] = 8'($urandom_range(0, 255));
      errAt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FB - 1)) : -1;
      for (int k = 0; k < FB; k++) sendByte(frameBuf[k], k != errAt, 1'b1);
      idleFor(int'($urandom_range(0, 3)) * CPB);
      checkOutput("random ready count", PW'(readyCount), PW'(modelReady));
      checkOutput("random data", data_out, modelData);
    end
    idleFor(30 * CPB);
    checkOutput("final ready count", PW'(readyCount), PW'(modelReady));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
